// File: rtl/timer_pkg.sv
// timer_pkg: shared register map, AHB encodings and types for the AHB timer
// slave and its reusable bus front end.
//   REG_*        word indices (haddr[4:2]) of the timer registers
//   HTRANS_*     AHB transfer types
//   HRESP_*      AHB response codes
//   ctrl_t       single-bit CTRL fields (prescale is parameterised, held apart)
//   err_state_t  states of the two-cycle ERROR response
package timer_pkg;

   localparam logic [2:0] REG_CTRL     = 3'd0;
   localparam logic [2:0] REG_STAT     = 3'd1;
   localparam logic [2:0] REG_MTIME_LO = 3'd2;
   localparam logic [2:0] REG_MTIME_HI = 3'd3;
   localparam logic [2:0] REG_CMP_LO   = 3'd4;
   localparam logic [2:0] REG_CMP_HI   = 3'd5;

   localparam logic [1:0] HTRANS_IDLE   = 2'b00;
   localparam logic [1:0] HTRANS_BUSY   = 2'b01;
   localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
   localparam logic [1:0] HTRANS_SEQ    = 2'b11;

   localparam logic HRESP_OKAY  = 1'b0;
   localparam logic HRESP_ERROR = 1'b1;

   localparam logic [2:0] HSIZE_WORD = 3'b010;

   typedef struct packed {
      logic irq_en;
      logic en;
   } ctrl_t;

   typedef enum logic [1:0] {
      ERR_IDLE,
      ERR_1,
      ERR_2
   } err_state_t;

   function automatic logic reg_mapped(input logic [2:0] idx);
      return idx <= REG_CMP_HI;
   endfunction

endpackage

// File: rtl/ahb_slave_port.sv
// ahb_slave_port: AHB-Lite address-phase capture plus the two-cycle ERROR
// response, shared by the peripheral slaves.
//   hclk, hrst            clock, synchronous active-high reset
//   hsel, hwrite, hready  select, direction, bus-wide HREADY
//   htrans, hsize         transfer type and size (only word size is legal)
//   addr_idx, addr_ok     word index of the address and whether it is mapped
//   hreadyout, hresp      slave response for the current data phase
//   dp_valid              a legal transfer is in its data phase
//   dp_write, dp_idx      direction and word index of that transfer
module ahb_slave_port
   import timer_pkg::*;
(
   input  logic       hclk,
   input  logic       hrst,
   input  logic       hsel,
   input  logic       hwrite,
   input  logic       hready,
   input  logic [1:0] htrans,
   input  logic [2:0] hsize,
   input  logic [2:0] addr_idx,
   input  logic       addr_ok,
   output logic       hreadyout,
   output logic       hresp,
   output logic       dp_valid,
   output logic       dp_write,
   output logic [2:0] dp_idx
);

   err_state_t state, state_next;
   logic       accept;
   logic       bad;

   assign accept = hsel & hready & ((htrans == HTRANS_NONSEQ) | (htrans == HTRANS_SEQ));
   assign bad    = (hsize != HSIZE_WORD) | ~addr_ok;

   always_ff @(posedge hclk) begin
      if (hrst) begin
         state    <= ERR_IDLE;
         dp_valid <= 1'b0;
         dp_write <= 1'b0;
         dp_idx   <= '0;
      end else begin
         state    <= state_next;
         dp_valid <= accept & ~bad;
         dp_write <= accept & hwrite;
         dp_idx   <= addr_idx;
      end
   end

   // ERR_2 drives hreadyout high, so a new address phase can be accepted
   // there; a second bad transfer restarts the sequence.
   always_comb begin
      state_next = state;
      hreadyout  = 1'b1;
      hresp      = HRESP_OKAY;
      case (state)
         ERR_IDLE: if (accept & bad) state_next = ERR_1;
         ERR_1: begin
            hreadyout  = 1'b0;
            hresp      = HRESP_ERROR;
            state_next = ERR_2;
         end
         ERR_2: begin
            hresp      = HRESP_ERROR;
            state_next = (accept & bad) ? ERR_1 : ERR_IDLE;
         end
         default: state_next = ERR_IDLE;
      endcase
   end

endmodule

// File: rtl/ahb_timer.sv
// ahb_timer: AHB-Lite timer slave with a prescaled 64-bit mtime counter and
// a 64-bit compare register driving a level timer interrupt.
//   hclk, hrst        clock, synchronous active-high reset
//   hsel_i .. haddr_i AHB-Lite slave inputs (hburst_i ignored)
//   hreadyout_o       slave ready, low only in the first ERROR cycle
//   hresp_o           0 = OKAY, 1 = ERROR
//   hrdata_o          read data, zero outside legal read data phases
//   timer_irq_o       registered interrupt (pending & irq_en)
module ahb_timer
   import timer_pkg::*;
#(
   parameter int AWIDTH     = 32,
   parameter int DWIDTH     = 32,
   parameter int PRESCALE_W = 8
) (
   input  logic              hclk,
   input  logic              hrst,
   input  logic              hsel_i,
   input  logic              hwrite_i,
   input  logic              hready_i,
   input  logic [2:0]        hsize_i,
   input  logic [2:0]        hburst_i,
   input  logic [1:0]        htrans_i,
   input  logic [DWIDTH-1:0] hwdata_i,
   input  logic [AWIDTH-1:0] haddr_i,
   output logic              hreadyout_o,
   output logic              hresp_o,
   output logic [DWIDTH-1:0] hrdata_o,
   output logic              timer_irq_o
);

   ctrl_t                 ctrl;
   logic [PRESCALE_W-1:0] prescale;
   logic [PRESCALE_W-1:0] pcnt;
   logic [63:0]           mtime;
   logic [63:0]           mtimecmp;
   logic [31:0]           hi_shadow;
   logic                  pending;
   logic                  pending_next;
   logic                  tick;
   logic                  dp_valid, dp_write;
   logic [2:0]            dp_idx;
   logic                  wr, rd;
   logic                  unused_bits;

   assign unused_bits = ^{hburst_i, haddr_i[AWIDTH-1:5], haddr_i[1:0]};

   ahb_slave_port u_port (
      .hclk      (hclk),
      .hrst      (hrst),
      .hsel      (hsel_i),
      .hwrite    (hwrite_i),
      .hready    (hready_i),
      .htrans    (htrans_i),
      .hsize     (hsize_i),
      .addr_idx  (haddr_i[4:2]),
      .addr_ok   (reg_mapped(haddr_i[4:2])),
      .hreadyout (hreadyout_o),
      .hresp     (hresp_o),
      .dp_valid  (dp_valid),
      .dp_write  (dp_write),
      .dp_idx    (dp_idx)
   );

   assign wr   = dp_valid & dp_write;
   assign rd   = dp_valid & ~dp_write;
   assign tick = ctrl.en & (pcnt == prescale);

   // Set beats a same-cycle W1C clear.
   assign pending_next = (ctrl.en & (mtime >= mtimecmp)) |
                         (pending & ~(wr & (dp_idx == REG_STAT) & hwdata_i[0]));

   always_ff @(posedge hclk) begin
      if (hrst) begin
         ctrl        <= '0;
         prescale    <= '0;
         pcnt        <= '0;
         mtime       <= '0;
         mtimecmp    <= '1;
         hi_shadow   <= '0;
         pending     <= 1'b0;
         timer_irq_o <= 1'b0;
      end else begin
         if (ctrl.en) pcnt <= tick ? '0 : pcnt + PRESCALE_W'(1);

         // A bus write to one half overrides the tick on that half and leaves
         // the other half at its pre-tick value (no carry across).
         if (wr && dp_idx == REG_MTIME_LO)
            mtime <= {mtime[63:32], hwdata_i[31:0]};
         else if (wr && dp_idx == REG_MTIME_HI)
            mtime <= {hwdata_i[31:0], mtime[31:0]};
         else
            mtime <= mtime + 64'(tick);

         if (wr && dp_idx == REG_CTRL) begin
            ctrl.en     <= hwdata_i[0];
            ctrl.irq_en <= hwdata_i[1];
            prescale    <= hwdata_i[8 +: PRESCALE_W];
         end
         if (wr && dp_idx == REG_CMP_LO) mtimecmp[31:0]  <= hwdata_i[31:0];
         if (wr && dp_idx == REG_CMP_HI) mtimecmp[63:32] <= hwdata_i[31:0];

         if (rd && dp_idx == REG_MTIME_LO) hi_shadow <= mtime[63:32];

         pending     <= pending_next;
         timer_irq_o <= pending_next & ctrl.irq_en;
      end
   end

   always_comb begin
      hrdata_o = '0;
      if (rd) begin
         case (dp_idx)
            REG_CTRL: begin
               hrdata_o[0]               = ctrl.en;
               hrdata_o[1]               = ctrl.irq_en;
               hrdata_o[8 +: PRESCALE_W] = prescale;
            end
            REG_STAT:     hrdata_o[0] = pending;
            REG_MTIME_LO: hrdata_o    = mtime[31:0];
            REG_MTIME_HI: hrdata_o    = hi_shadow;
            REG_CMP_LO:   hrdata_o    = mtimecmp[31:0];
            REG_CMP_HI:   hrdata_o    = mtimecmp[63:32];
            default:      hrdata_o    = '0;
         endcase
      end
   end

endmodule

// File: tb/tb_ahb_timer.sv
// tb_ahb_timer: directed and random bus traffic against ahb_timer, checked
// every cycle against a cycle-level reference model of the register rules.
module tb_ahb_timer;
   import timer_pkg::*;

   logic        hclk = 1'b0;
   logic        hrst;
   logic        hsel_i, hwrite_i, hready_i;
   logic [2:0]  hsize_i, hburst_i;
   logic [1:0]  htrans_i;
   logic [31:0] hwdata_i, haddr_i;
   logic        hreadyout_o, hresp_o, timer_irq_o;
   logic [31:0] hrdata_o;

   always #5 hclk = ~hclk;

   ahb_timer #(.AWIDTH(32), .DWIDTH(32), .PRESCALE_W(8)) dut (
      .hclk(hclk), .hrst(hrst), .hsel_i(hsel_i), .hwrite_i(hwrite_i),
      .hready_i(hready_i), .hsize_i(hsize_i), .hburst_i(hburst_i),
      .htrans_i(htrans_i), .hwdata_i(hwdata_i), .haddr_i(haddr_i),
      .hreadyout_o(hreadyout_o), .hresp_o(hresp_o), .hrdata_o(hrdata_o),
      .timer_irq_o(timer_irq_o)
   );

   int unsigned n_checks = 0;
   int unsigned n_pass   = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, got, exp);
   endtask

   // reference model state
   bit          m_en, m_irq_en;
   bit [7:0]    m_pre, m_pcnt;
   bit [63:0]   m_mtime, m_cmp;
   bit [31:0]   m_shadow;
   bit          m_pend, m_irq;
   int unsigned m_errph;          // 2 = first ERROR cycle, 1 = second, 0 = none
   bit          m_dv, m_dw;
   int unsigned m_da;
   logic [31:0] last_rd;

   task automatic model_reset();
      m_en = 0; m_irq_en = 0; m_pre = 0; m_pcnt = 0;
      m_mtime = 0; m_cmp = 64'hFFFF_FFFF_FFFF_FFFF; m_shadow = 0;
      m_pend = 0; m_irq = 0; m_errph = 0; m_dv = 0; m_dw = 0; m_da = 0;
   endtask

   function automatic bit [31:0] m_reg(input int unsigned idx);
      bit [31:0] v = 0;
      case (idx)
         0: begin v[0] = m_en; v[1] = m_irq_en; v[15:8] = m_pre; end
         1: v[0] = m_pend;
         2: v = m_mtime[31:0];
         3: v = m_shadow;
         4: v = m_cmp[31:0];
         5: v = m_cmp[63:32];
         default: v = 0;
      endcase
      return v;
   endfunction

   task automatic model_step();
      bit          accept, bad, wr, tick, set, clr, irq_en_old;
      int unsigned idx;
      bit [63:0]   t_old;
      if (hrst) model_reset();
      else begin
         idx        = haddr_i[4:2];
         accept     = hsel_i && htrans_i[1] && hready_i;
         bad        = (hsize_i != 3'b010) || (idx > 5);
         wr         = m_dv && m_dw;
         tick       = m_en && (m_pcnt == m_pre);
         t_old      = m_mtime;
         set        = m_en && (m_mtime >= m_cmp);
         clr        = wr && m_da == 1 && hwdata_i[0];
         irq_en_old = m_irq_en;
         if (m_en) m_pcnt = tick ? 8'd0 : m_pcnt + 8'd1;
         if (tick) m_mtime = m_mtime + 64'd1;
         if (m_dv && !m_dw && m_da == 2) m_shadow = t_old[63:32];
         m_pend = set || (m_pend && !clr);
         m_irq  = m_pend && irq_en_old;
         if (wr) begin
            case (m_da)
               0: begin m_en = hwdata_i[0]; m_irq_en = hwdata_i[1]; m_pre = hwdata_i[15:8]; end
               2: m_mtime = {t_old[63:32], hwdata_i};
               3: m_mtime = {hwdata_i, t_old[31:0]};
               4: m_cmp[31:0]  = hwdata_i;
               5: m_cmp[63:32] = hwdata_i;
               default: ;
            endcase
         end
         m_errph = (accept && bad) ? 2 : ((m_errph == 2) ? 1 : 0);
         m_dv = accept && !bad;
         m_dw = hwrite_i;
         m_da = idx;
      end
   endtask

   // One clock: check the current data-phase outputs, advance the model,
   // then let the DUT take the edge.
   task automatic cyc();
      logic [31:0] exp_rd;
      hready_i = (m_errph != 2);
      #1;
      exp_rd = (m_dv && !m_dw) ? m_reg(m_da) : 32'h0;
      check("hreadyout", {63'h0, hreadyout_o}, {63'h0, m_errph != 2});
      check("hresp", {63'h0, hresp_o}, {63'h0, m_errph != 0});
      check("hrdata", {32'h0, hrdata_o}, {32'h0, exp_rd});
      check("irq", {63'h0, timer_irq_o}, {63'h0, m_irq});
      if (m_dv && !m_dw) last_rd = hrdata_o;
      model_step();
      @(posedge hclk);
      #1;
   endtask

   task automatic addr_ph(input bit w, input logic [31:0] a, input logic [2:0] sz);
      hsel_i = 1; hwrite_i = w; htrans_i = HTRANS_NONSEQ; haddr_i = a; hsize_i = sz;
   endtask

   task automatic idle_ph();
      hsel_i = 0; hwrite_i = 0; htrans_i = HTRANS_IDLE; haddr_i = 0; hsize_i = 3'b010;
   endtask

   task automatic xfer(input bit w, input logic [31:0] a, input logic [31:0] d, input logic [2:0] sz);
      addr_ph(w, a, sz);
      cyc();
      idle_ph();
      hwdata_i = d;
      cyc();
      for (int i = 0; i < 4 && m_errph != 0; i++) cyc();
   endtask

   task automatic wr(input logic [31:0] a, input logic [31:0] d);
      xfer(1'b1, a, d, 3'b010);
   endtask

   task automatic rd(input logic [31:0] a);
      xfer(1'b0, a, 32'h0, 3'b010);
   endtask

   task automatic wr_rd(input logic [31:0] a1, input logic [31:0] d1, input logic [31:0] a2);
      addr_ph(1'b1, a1, 3'b010); cyc();
      addr_ph(1'b0, a2, 3'b010); hwdata_i = d1; cyc();
      idle_ph(); cyc();
   endtask

   task automatic wr_wr(input logic [31:0] a1, input logic [31:0] d1,
                        input logic [31:0] a2, input logic [31:0] d2);
      addr_ph(1'b1, a1, 3'b010); cyc();
      addr_ph(1'b1, a2, 3'b010); hwdata_i = d1; cyc();
      idle_ph(); hwdata_i = d2; cyc();
   endtask

   initial begin
      logic [31:0] rst_vals [6];
      rst_vals = '{32'h0, 32'h0, 32'h0, 32'h0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
      hrst = 1; hburst_i = 3'b000; hwdata_i = 0; hready_i = 1; last_rd = 0;
      idle_ph();
      @(posedge hclk); #1;
      model_reset();
      cyc(); cyc();
      hrst = 0;

      // reset state
      check("rst_hreadyout", {63'h0, hreadyout_o}, 64'h1);
      check("rst_hresp", {63'h0, hresp_o}, 64'h0);
      check("rst_hrdata", {32'h0, hrdata_o}, 64'h0);
      check("rst_irq", {63'h0, timer_irq_o}, 64'h0);
      for (int i = 0; i < 6; i++) begin
         rd(32'(i * 4));
         check("rst_reg", {32'h0, last_rd}, {32'h0, rst_vals[i]});
      end

      // prescale = 3: one tick every 4 enabled cycles
      wr(32'h00, 32'h0000_0301);
      for (int k = 1; k <= 9; k++) begin
         cyc(); cyc();
         rd(32'h08);
         check("mtime_run", {32'h0, last_rd}, 64'(k - 1));
      end
      cyc(); cyc();
      wr(32'h00, 32'h0000_0300);
      rd(32'h08);
      check("mtime_40cyc", {32'h0, last_rd}, 64'd10);

      // unmapped write, then byte-size read: two-cycle ERROR, no side effect
      addr_ph(1'b1, 32'h1C, 3'b010); cyc();
      idle_ph(); hwdata_i = 32'hDEAD_BEEF;
      check("err1_rdy", {63'h0, hreadyout_o}, 64'h0);
      check("err1_resp", {63'h0, hresp_o}, 64'h1);
      cyc();
      check("err2_rdy", {63'h0, hreadyout_o}, 64'h1);
      check("err2_resp", {63'h0, hresp_o}, 64'h1);
      check("err2_rdata", {32'h0, hrdata_o}, 64'h0);
      cyc();
      check("err_done", {63'h0, hresp_o}, 64'h0);
      xfer(1'b0, 32'h00, 32'h0, 3'b000);
      rd(32'h00);
      check("ctrl_kept", {32'h0, last_rd}, 64'h300);

      // carry from the low to the high word, coherent 64-bit read
      wr(32'h08, 32'hFFFF_FFFF);
      wr(32'h0C, 32'h0);
      wr_wr(32'h00, 32'h0000_0001, 32'h00, 32'h0);
      rd(32'h08);
      check("carry_lo", {32'h0, last_rd}, 64'h0);
      rd(32'h0C);
      check("carry_hi", {32'h0, last_rd}, 64'h1);

      // compare, interrupt, W1C while over compare
      wr(32'h14, 32'h0);
      wr(32'h10, 32'h20);
      wr(32'h08, 32'h0);
      wr(32'h0C, 32'h0);
      wr(32'h00, 32'h0000_0003);
      for (int i = 0; i < 100 && !m_irq; i++) cyc();
      check("irq_up", {63'h0, timer_irq_o}, 64'h1);
      rd(32'h04);
      check("stat_set", {32'h0, last_rd}, 64'h1);
      wr(32'h04, 32'h1);
      rd(32'h04);
      check("stat_w1c_held", {32'h0, last_rd}, 64'h1);
      wr(32'h00, 32'h0000_0002);
      wr(32'h04, 32'h1);
      rd(32'h04);
      check("stat_cleared", {32'h0, last_rd}, 64'h0);
      check("irq_down", {63'h0, timer_irq_o}, 64'h0);

      // write then read back to back; reset during an ERROR response
      wr_rd(32'h10, 32'h55, 32'h10);
      check("b2b_cmp_lo", {32'h0, last_rd}, 64'h55);
      addr_ph(1'b0, 32'h18, 3'b010); cyc();
      idle_ph();
      hrst = 1; cyc(); hrst = 0;
      check("rst_err_rdy", {63'h0, hreadyout_o}, 64'h1);
      check("rst_err_resp", {63'h0, hresp_o}, 64'h0);
      rd(32'h10);
      check("rst_cmp_lo", {32'h0, last_rd}, 64'hFFFF_FFFF);

      // random traffic
      for (int n = 0; n < 250; n++) begin
         int unsigned op, idx;
         logic [31:0] d;
         op = $urandom_range(0, 9);
         case (op)
            0: wr(32'h00, ($urandom_range(0, 3) << 8) | $urandom_range(0, 3));
            1: wr(32'h04, $urandom_range(0, 1));
            2, 3: begin
               idx = $urandom_range(2, 5);
               if (idx == 2)      d = $urandom_range(0, 1) ? $urandom_range(0, 80) : 32'hFFFF_FFFF - $urandom_range(0, 3);
               else if (idx == 4) d = $urandom_range(0, 100);
               else               d = $urandom_range(0, 1);
               wr(32'(idx * 4), d);
            end
            4, 5, 6: rd(32'($urandom_range(0, 7) * 4));
            7: xfer($urandom_range(0, 1) == 1, 32'($urandom_range(0, 5) * 4), $urandom, 3'($urandom_range(0, 1)));
            8: begin
               hsel_i = 1; hwrite_i = $urandom_range(0, 1) == 1;
               htrans_i = $urandom_range(0, 1) == 1 ? HTRANS_BUSY : HTRANS_IDLE;
               haddr_i = 32'($urandom_range(0, 5) * 4); hsize_i = 3'b010; hwdata_i = $urandom;
               cyc();
               idle_ph(); cyc();
            end
            default: wr_rd(32'($urandom_range(0, 5) * 4), $urandom_range(0, 100), 32'($urandom_range(0, 5) * 4));
         endcase
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
